// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signal bundle for the store buffer.
// The slave modport is the buffer's own view; master is the environment (core + data memory).
interface store_buffer_if #(
    parameter int unsigned AW = 32
);
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          flush;
    logic [31:0]   cpu_rdata;
    logic          stall;
    logic          empty;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    modport master (
        output cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
        input  cpu_rdata, stall, empty, mem_req, mem_addr, mem_wdata, mem_raddr
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
        output cpu_rdata, stall, empty, mem_req, mem_addr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/store_buffer.sv
// Write-back store buffer: a circular FIFO of pending stores drained to data memory,
// with word-granular load forwarding and a fence that drains the buffer before new stores.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, FENCE} state_t;

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;

    logic push;
    logic pop;
    logic [31:0] fwd_data;

    // Status decodes straight from registers so reset clears them without waiting for an edge.
    assign bus.stall     = (count == CW'(DEPTH)) | (state == FENCE);
    assign bus.empty     = (count == '0);
    assign bus.mem_req   = (count != '0);
    assign bus.mem_addr  = addr_q[rd_ptr];
    assign bus.mem_wdata = data_q[rd_ptr];
    assign bus.mem_raddr = bus.cpu_addr;
    assign bus.cpu_rdata = fwd_data;

    assign push = bus.cpu_we & ~bus.stall;
    assign pop  = (count != '0) & bus.mem_ack;

    // Entry storage; contents need no reset because count gates their validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.cpu_addr;
            data_q[wr_ptr] <= bus.cpu_wdata;
        end
    end

    // Pointers, occupancy and the RUN/FENCE drain state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= RUN;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case (state)
                RUN:     if (bus.flush && (count != '0)) state <= FENCE;
                FENCE:   if (pop && (count == CW'(1))) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Walk oldest to youngest so the youngest matching word wins; the head still counts while popping.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_data = bus.mem_rdata;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (addr_q[idx][AW-1:2] == bus.cpu_addr[AW-1:2]))
                fwd_data = data_q[idx];
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: fill, drain order, forwarding, full-with-ack,
// fence and asynchronous reset behaviour.
module tb_store_buffer;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    store_buffer_if #(.AW(32)) bus ();

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        step();
        bus.cpu_we    = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h1234_5678;

        // Reset state
        step();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_stall",   32'(bus.stall),   32'd0);
        check("rst_empty",   32'(bus.empty),   32'd1);
        reset = 1'b0;

        // Fill four entries with no ack
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
        check("fill_stall",    32'(bus.stall),   32'd1);
        check("fill_empty",    32'(bus.empty),   32'd0);
        check("fill_mem_req",  32'(bus.mem_req), 32'd1);
        check("fill_head",     bus.mem_addr,     32'h100);
        store(32'h110, 32'h0000_0055);
        check("fifth_stall",   32'(bus.stall),   32'd1);
        check("fifth_head",    bus.mem_addr,     32'h100);
        bus.cpu_addr = 32'h110;
        #1 check("fifth_not_enq", bus.cpu_rdata, 32'h1234_5678);
        bus.cpu_addr = 32'h10C;
        #1 check("fwd_tail",      bus.cpu_rdata, 32'h0000_1003);

        // Drain in order
        bus.mem_ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check("drain_addr",  bus.mem_addr,  32'h100 + 32'(4 * i));
            check("drain_wdata", bus.mem_wdata, 32'h1000 + 32'(i));
        end
        step();
        check("drain_empty",   32'(bus.empty),   32'd1);
        check("drain_mem_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;

        // Forwarding: youngest match wins, byte offset ignored
        store(32'h200, 32'hAAAA_0000);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h200;
        bus.cpu_wdata = 32'hBBBB_0000;
        #1 check("fwd_next_cycle", bus.cpu_rdata, 32'hAAAA_0000);
        step();
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h202;
        #1 check("fwd_youngest", bus.cpu_rdata, 32'hBBBB_0000);
        bus.cpu_addr = 32'h300;
        #1 check("fwd_miss",     bus.cpu_rdata, 32'h1234_5678);
        check("mem_raddr",       bus.mem_raddr, 32'h300);
        bus.mem_ack = 1'b1;
        step();
        bus.cpu_addr = 32'h200;
        #1 check("fwd_popping",  bus.cpu_rdata, 32'hBBBB_0000);
        step();
        bus.mem_ack = 1'b0;
        check("fwd_after_pop",   bus.cpu_rdata, 32'h1234_5678);
        check("fwd_pop_empty",   32'(bus.empty), 32'd1);

        // Full with ack: pop only, store taken on the following cycle
        for (int i = 0; i < 4; i++) store(32'h400 + 32'(4 * i), 32'h4000 + 32'(i));
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h500;
        bus.cpu_wdata = 32'h0000_5555;
        bus.mem_ack   = 1'b1;
        #1 check("fullack_stall", 32'(bus.stall), 32'd1);
        step();
        bus.mem_ack = 1'b0;
        check("fullack_pop_head", bus.mem_addr,   32'h404);
        check("fullack_stall_lo", 32'(bus.stall), 32'd0);
        step();
        bus.cpu_we = 1'b0;
        check("fullack_refull",   32'(bus.stall), 32'd1);
        check("fullack_fwd",      bus.cpu_rdata,  32'h0000_5555);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.mem_ack = 1'b0;
        check("fullack_empty",    32'(bus.empty), 32'd1);

        // Fence with two entries
        store(32'h600, 32'h6);
        store(32'h604, 32'h7);
        bus.flush = 1'b1;
        step();
        bus.flush     = 1'b0;
        check("fence_stall0", 32'(bus.stall), 32'd1);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h700;
        bus.cpu_wdata = 32'h0000_0777;
        bus.mem_ack   = 1'b1;
        step();
        check("fence_stall1", 32'(bus.stall), 32'd1);
        step();
        bus.cpu_we  = 1'b0;
        bus.mem_ack = 1'b0;
        check("fence_release", 32'(bus.stall), 32'd0);
        check("fence_empty",   32'(bus.empty), 32'd1);
        #1 check("fence_ignored_we", bus.cpu_rdata, 32'h1234_5678);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_empty_nostall", 32'(bus.stall), 32'd0);

        // Asynchronous reset between edges discards pending stores
        for (int i = 0; i < 3; i++) store(32'h900 + 32'(4 * i), 32'h9000 + 32'(i));
        check("pre_rst_req", 32'(bus.mem_req), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_req",   32'(bus.mem_req), 32'd0);
        check("async_rst_empty", 32'(bus.empty),   32'd1);
        check("async_rst_stall", 32'(bus.stall),   32'd0);
        reset = 1'b0;

        // First store after reset release
        store(32'h800, 32'h0000_0888);
        check("post_rst_empty", 32'(bus.empty), 32'd0);
        check("post_rst_head",  bus.mem_addr,   32'h800);
        check("post_rst_data",  bus.mem_wdata,  32'h0000_0888);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered store entries; power of two, 2..16.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 cpu_we  input  1  CPU store request, sampled each cycle; this is the core's MemWrite.
REQ-006 cpu_addr  input  AW  CPU load/store byte address; this is the core's Mem_WrAddr.
REQ-007 cpu_wdata  input  32  CPU store data; this is the core's Mem_WrData.
REQ-008 flush  input  1  fence request; drain all entries before new stores are accepted.
REQ-009 cpu_rdata  output  32  load data to the core's ReadData; forwarded or from memory.
REQ-010 stall  output  1  CPU must hold its current instruction this cycle.
REQ-011 empty  output  1  no entries held.
REQ-012 mem_req  output  1  write request to data memory.
REQ-013 mem_addr  output  AW  head-entry write address.
REQ-014 mem_wdata  output  32  head-entry write data.
REQ-015 mem_ack  input  1  memory accepted the current write.
REQ-016 mem_raddr  output  AW  load address to memory; equals cpu_addr, combinational.
REQ-017 mem_rdata  input  32  memory load data, combinational for mem_raddr.

Function
REQ-018 Storage: circular FIFO of DEPTH entries {addr, data}; wr_ptr, rd_ptr wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-019 Enqueue: on a clock edge with cpu_we=1, stall=0, write {cpu_addr, cpu_wdata} at wr_ptr, then increment wr_ptr and count.
REQ-020 Full: stall=1 whenever count==DEPTH, even if mem_ack=1 that cycle; no enqueue occurs while stall=1.
REQ-021 Drain: mem_req = (count!=0); mem_addr and mem_wdata = entry at rd_ptr, held stable until acknowledged.
REQ-022 Pop: on a clock edge with mem_req=1 and mem_ack=1, increment rd_ptr and decrement count.
REQ-023 mem_ack while mem_req=0 is ignored.
REQ-024 Simultaneous enqueue and pop: count unchanged; both pointers advance.
REQ-025 Forwarding: the address match compares addr[AW-1:2] only.
REQ-026 cpu_rdata = data of the youngest valid entry matching cpu_addr; with no match, cpu_rdata = mem_rdata.
REQ-027 An entry being popped in the current cycle still forwards in that cycle.
REQ-028 A store enqueued in cycle N is forwardable from cycle N+1.
REQ-029 Drain FSM states: RUN and FENCE.
REQ-030 RUN -> FENCE when flush=1 and count!=0.
REQ-031 FENCE -> RUN on the edge where count becomes 0.
REQ-032 In FENCE, stall=1 and cpu_we is ignored.
REQ-033 flush=1 with count==0 stays in RUN and produces no stall.
REQ-034 Stall equation: stall = (count==DEPTH) | (state==FENCE).
REQ-035 empty = (count==0).

Reset
REQ-036 While reset=1: count=0, wr_ptr=0, rd_ptr=0, state=RUN, mem_req=0, stall=0, empty=1; entry contents are don't-care.
REQ-037 Reset asserted mid-handshake: pending entries are discarded, and mem_req deasserts asynchronously.
REQ-038 After reset release, the first edge with cpu_we=1 enqueues normally.

Verification
REQ-039 Fill test: 4 stores to 0x100, 0x104, 0x108, 0x10C with mem_ack=0 -> count=4, stall=1, and a 5th store is not enqueued.
REQ-040 Drain order test: then mem_ack=1 -> mem_addr shows 0x100, 0x104, 0x108, 0x10C on consecutive cycles; empty=1 afterwards.
REQ-041 Forwarding test: store 0xAAAA0000 then 0xBBBB0000 to 0x200, no ack, load 0x202 -> cpu_rdata=0xBBBB0000; load 0x300 -> cpu_rdata=mem_rdata.
REQ-042 Full-with-ack test: count=4 and mem_ack=1 with cpu_we=1 -> pop only, count=3, stall=1 that cycle; the store is accepted the next cycle.
REQ-043 Fence test: 2 entries, flush=1 -> stall=1 until the second ack edge; stall=0 the cycle after count=0.
REQ-044 Reset test: async reset pulse between clock edges while count=3 and mem_req=1 -> mem_req=0 and empty=1 before the next edge.
